mcpu_soc_mmio_arb: RTL and testbench
====================================

// Module: mcpu_soc_mmio_arb
// PURPOSE
//  Round-robin arbiter sharing the single MMIO peripheral port (LED/SW, UART, I2C, SD, audio) between NREQ masters
//  (core data port, debug/DMA). Registers winning address/strobes, holds them stable for the access, captures read
//  data after a fixed settle time, returns it with a one-cycle response pulse. One access in flight at a time.
// PARAMETERS
//  NREQ       2  number of requesters (2..4)
//  READ_WAIT  1  cycles addr is held before mmio_data_out is captured (1..15)
// PORTS
//  clkrst_core_clk  in   1         core clock; all logic on rising edge
//  clkrst_core_rst  in   1         asynchronous, active-high reset
//  req_valid        in   NREQ      requester i has an access pending
//  req_addr         in   NREQ*29   word address [30:2], requester i at [i*29 +: 29]
//  req_wren         in   NREQ*4    byte write enables; 4'h0 = read
//  req_wdata        in   NREQ*32   write data
//  req_ready        out  NREQ      one-hot accept pulse; request consumed on this cycle
//  rsp_valid        out  NREQ      one-hot, one-cycle response pulse
//  rsp_data         out  32        read data (shared, valid with rsp_valid)
//  rsp_err          out  1         decode error flag (valid with rsp_valid)
//  mmio_addr        out  29        to MMIO port addr[30:2]
//  mmio_wren        out  4         to MMIO port wren
//  mmio_data_in     out  32        to MMIO port data_in
//  mmio_data_out    in   32        from MMIO port data_out (combinational on addr)
// BEHAVIOUR
//  Reset: state IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, mmio_addr=0, mmio_wren=0,
//   mmio_data_in=0, wait counter 0. Reset mid-access aborts it; no response issued.
//  FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  IDLE: if any req_valid, pick first set bit searching from rr_ptr upward (wrap at NREQ); pulse req_ready[g];
//   latch addr/wren/wdata/grant into mmio_* regs; rr_ptr <= (g+1) mod NREQ; go ISSUE. Else stay.
//  ISSUE: mmio_wren driven with latched strobes for exactly this cycle; counter <= READ_WAIT-1; go WAIT.
//  WAIT: mmio_wren=0, mmio_addr held; counter==0 -> capture mmio_data_out into rsp_data, go RESP; else decrement.
//  RESP: rsp_valid[g]=1 for one cycle; go IDLE. Writes also get a response (rsp_data=captured value, ignored).
//  Latency: req_ready at cycle T, mmio_wren at T+1, rsp_valid at T+3+READ_WAIT-1. Throughput one access per
//   3+READ_WAIT cycles. Requesters must hold req_* until req_ready; arbiter ignores req_valid outside IDLE.
//  Simultaneous requests: rotating priority guarantees no starvation; worst-case wait NREQ-1 accesses.
//  mmio_wren is never nonzero outside ISSUE; mmio_addr changes only on IDLE->ISSUE.
// CONFIGURATION
//  MCPU_SOC_MMIO_ARB_DECERR_EN defined: addr[30:12] > 19'd4 (unmapped) -> mmio_wren forced 0 in ISSUE,
//   rsp_data=32'hDEAD_BEEF, rsp_err=1. Timing unchanged.
//  Undefined: no decode; unmapped accesses pass through, rsp_err tied 0.
// STRUCTURE
//  Shared package/header mcpu_soc_mmio_defs: MMIO region indices (LEDSW=0,UART=1,I2C=2,SD=3,AUDIO=4),
//   MMIO_NREGIONS=5, FSM state encoding, DEADBEEF constant.
//  Sub-module mcpu_soc_rr_pick: combinational rotating first-one picker (req vector, ptr -> one-hot grant, index).
// TESTING
//  Single read: req0 addr 29'h400 (UART), data_out=32'h55 -> ready0 pulse, rsp_valid0 after 3 cycles, data 32'h55.
//  Write: req1 addr 0, wren 4'h3, wdata 32'hABCD -> mmio_wren=4'h3 exactly one cycle, rsp_valid1 pulse.
//  Contention: req0,req1 held high 4 accesses -> grants alternate 0,1,0,1; READ_WAIT=3 gives period 6 cycles.
//  Reset asserted in WAIT -> all outputs 0 next cycle, no rsp_valid, rr_ptr=0, next grant to req0.
//  DECERR_EN: write to addr[30:12]=19'd7 -> mmio_wren stays 0, rsp_err=1, rsp_data=32'hDEADBEEF; undefined: err=0.
//  NREQ=3 all requesting, rr_ptr=2 -> grant order 2,0,1.

Source files
------------

// File: rtl/mcpu_soc_mmio_defs.sv
// mcpu_soc_mmio_defs: MMIO region map, arbiter FSM encoding and decode helper.
package mcpu_soc_mmio_defs;
  localparam int REG_LEDSW = 0;
  localparam int REG_UART = 1;
  localparam int REG_I2C = 2;
  localparam int REG_SD = 3;
  localparam int REG_AUDIO = 4;
  localparam int MMIO_NREGIONS = 5;
  localparam logic [31:0] DEADBEEF = 32'hDEAD_BEEF;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
  // Word address bits [28:10] are byte address bits [30:12], the 4 KiB region index.
  function automatic logic is_unmapped(input logic [28:0] addr);
    return addr[28:10] > 19'(MMIO_NREGIONS - 1);
  endfunction
endpackage

// File: rtl/mcpu_soc_mmio_arb_if.sv
// mcpu_soc_mmio_arb_if: requester and MMIO port signals of the MMIO arbiter.
interface mcpu_soc_mmio_arb_if #(parameter int NREQ = 2);
  logic [NREQ-1:0] req_valid;
  logic [NREQ*29-1:0] req_addr;
  logic [NREQ*4-1:0] req_wren;
  logic [NREQ*32-1:0] req_wdata;
  logic [NREQ-1:0] req_ready;
  logic [NREQ-1:0] rsp_valid;
  logic [31:0] rsp_data;
  logic rsp_err;
  logic [28:0] mmio_addr;
  logic [3:0] mmio_wren;
  logic [31:0] mmio_data_in;
  logic [31:0] mmio_data_out;
  modport master (
    output req_valid, req_addr, req_wren, req_wdata, mmio_data_out,
    input req_ready, rsp_valid, rsp_data, rsp_err, mmio_addr, mmio_wren, mmio_data_in
  );
  modport slave (
    input req_valid, req_addr, req_wren, req_wdata, mmio_data_out,
    output req_ready, rsp_valid, rsp_data, rsp_err, mmio_addr, mmio_wren, mmio_data_in
  );
endinterface

// File: rtl/mcpu_soc_rr_pick.sv
// mcpu_soc_rr_pick: rotating first-one picker, searching upward from ptr with wrap.
module mcpu_soc_rr_pick #(
  parameter int NREQ = 2,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);
  function automatic logic [IW-1:0] wrap(input logic [IW-1:0] p, input int o);
    int s;
    s = int'(p) + o;
    return IW'(s >= NREQ ? s - NREQ : s);
  endfunction
  // Scan from the farthest offset down so the nearest set bit wins last.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[wrap(ptr, i)]) begin
        idx = wrap(ptr, i);
        any = 1'b1;
      end
    end
  end
  assign grant = any ? NREQ'(1) << idx : '0;
endmodule

// File: rtl/mcpu_soc_mmio_arb.sv
// mcpu_soc_mmio_arb: round-robin arbiter sharing one MMIO port among NREQ masters.
// Define MCPU_SOC_MMIO_ARB_DECERR_EN to flag unmapped regions instead of passing them through.
module mcpu_soc_mmio_arb
  import mcpu_soc_mmio_defs::*;
#(
  parameter int NREQ = 2,
  parameter int READ_WAIT = 1
) (
  input logic clkrst_core_clk,
  input logic clkrst_core_rst,
  mcpu_soc_mmio_arb_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  state_t state, nxt;
  logic [IW-1:0] ptr, pick_idx;
  logic [NREQ-1:0] pick_grant, g_oh;
  logic pick_any, dec, err_q;
  logic [3:0] cnt;
  logic [28:0] sel_addr;
  logic [3:0] sel_wren;
  logic [31:0] sel_wdata;
  mcpu_soc_rr_pick #(.NREQ(NREQ)) u_pick (
    .req(bus.req_valid),
    .ptr(ptr),
    .grant(pick_grant),
    .idx(pick_idx),
    .any(pick_any)
  );
  assign sel_addr = bus.req_addr[int'(pick_idx)*29 +: 29];
  assign sel_wren = bus.req_wren[int'(pick_idx)*4 +: 4];
  assign sel_wdata = bus.req_wdata[int'(pick_idx)*32 +: 32];
`ifdef MCPU_SOC_MMIO_ARB_DECERR_EN
  assign dec = is_unmapped(sel_addr);
`else
  assign dec = 1'b0;
`endif
  always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst)
    if (clkrst_core_rst) state <= S_IDLE;
    else state <= nxt;
  // Accept is combinational so a requester sees it in the cycle its request is consumed.
  always_comb begin
    nxt = state;
    bus.req_ready = '0;
    nxt = state == S_IDLE  ? (pick_any ? S_ISSUE : S_IDLE) :
          state == S_ISSUE ? S_WAIT :
          state == S_WAIT  ? (cnt == 4'd0 ? S_RESP : S_WAIT) : S_IDLE;
    bus.req_ready = (state == S_IDLE && !clkrst_core_rst) ? pick_grant : '0;
  end
  always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
    if (clkrst_core_rst) begin
      ptr <= '0;
      g_oh <= '0;
      err_q <= 1'b0;
      cnt <= '0;
      bus.mmio_addr <= '0;
      bus.mmio_wren <= '0;
      bus.mmio_data_in <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_data <= '0;
      bus.rsp_err <= 1'b0;
    end else begin
      bus.rsp_valid <= '0;
      if (state == S_IDLE && pick_any) begin
        ptr <= int'(pick_idx) == NREQ - 1 ? '0 : pick_idx + 1'b1;
        g_oh <= pick_grant;
        err_q <= dec;
        bus.mmio_addr <= sel_addr;
        bus.mmio_wren <= dec ? 4'h0 : sel_wren;
        bus.mmio_data_in <= sel_wdata;
      end
      if (state == S_ISSUE) begin
        bus.mmio_wren <= '0;
        cnt <= 4'(READ_WAIT - 1);
      end
      if (state == S_WAIT) begin
        if (cnt == 4'd0) begin
          bus.rsp_data <= err_q ? DEADBEEF : bus.mmio_data_out;
          bus.rsp_err <= err_q;
          bus.rsp_valid <= g_oh;
        end else cnt <= cnt - 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_mcpu_soc_mmio_arb.sv
// tb_mcpu_soc_mmio_arb: directed checks on three arbiter configurations.
module tb_mcpu_soc_mmio_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  mcpu_soc_mmio_arb_if #(.NREQ(2)) a ();
  mcpu_soc_mmio_arb_if #(.NREQ(2)) b ();
  mcpu_soc_mmio_arb_if #(.NREQ(3)) c ();
  mcpu_soc_mmio_arb #(.NREQ(2), .READ_WAIT(1)) u0 (.clkrst_core_clk(clk), .clkrst_core_rst(rst), .bus(a.slave));
  mcpu_soc_mmio_arb #(.NREQ(2), .READ_WAIT(3)) u1 (.clkrst_core_clk(clk), .clkrst_core_rst(rst), .bus(b.slave));
  mcpu_soc_mmio_arb #(.NREQ(3), .READ_WAIT(1)) u2 (.clkrst_core_clk(clk), .clkrst_core_rst(rst), .bus(c.slave));
  assign b.mmio_data_out = {3'b0, b.mmio_addr} + 32'd1;
  assign c.mmio_data_out = {3'b0, c.mmio_addr} + 32'd1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    logic [1:0] eg;
    logic [31:0] ea;
    a.req_valid = 2'b11; a.req_addr = '0; a.req_wren = '0; a.req_wdata = '0; a.mmio_data_out = '0;
    b.req_valid = '0; b.req_addr = '0; b.req_wren = '0; b.req_wdata = '0;
    c.req_valid = '0; c.req_addr = '0; c.req_wren = '0; c.req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(a.req_ready), 32'h0);
    chk("rst_rspv", 32'(a.rsp_valid), 32'h0);
    chk("rst_data", a.rsp_data, 32'h0);
    chk("rst_err", 32'(a.rsp_err), 32'h0);
    chk("rst_addr", 32'(a.mmio_addr), 32'h0);
    chk("rst_wren", 32'(a.mmio_wren), 32'h0);
    chk("rst_din", a.mmio_data_in, 32'h0);
    a.req_valid = 2'b00;
    rst = 1'b0;
    @(negedge clk);
    a.req_valid = 2'b01; a.req_addr[28:0] = 29'h400; a.req_wren[3:0] = 4'h0; a.mmio_data_out = 32'h55;
    #1 chk("rd_ready", 32'(a.req_ready), 32'h1);
    @(negedge clk);
    a.req_valid = 2'b00;
    #1 chk("rd_addr", 32'(a.mmio_addr), 32'h400);
    chk("rd_wren", 32'(a.mmio_wren), 32'h0);
    chk("rd_ready_off", 32'(a.req_ready), 32'h0);
    @(negedge clk);
    chk("rd_wait_rspv", 32'(a.rsp_valid), 32'h0);
    @(negedge clk);
    chk("rd_rspv", 32'(a.rsp_valid), 32'h1);
    chk("rd_data", a.rsp_data, 32'h55);
    chk("rd_err", 32'(a.rsp_err), 32'h0);
    @(negedge clk);
    chk("rd_rspv_clr", 32'(a.rsp_valid), 32'h0);
    a.req_valid = 2'b10; a.req_addr[57:29] = 29'h0; a.req_wren[7:4] = 4'h3; a.req_wdata[63:32] = 32'hABCD;
    #1 chk("wr_ready", 32'(a.req_ready), 32'h2);
    @(negedge clk);
    a.req_valid = 2'b00;
    #1 chk("wr_wren", 32'(a.mmio_wren), 32'h3);
    chk("wr_din", a.mmio_data_in, 32'hABCD);
    chk("wr_addr", 32'(a.mmio_addr), 32'h0);
    @(negedge clk);
    chk("wr_wren_off", 32'(a.mmio_wren), 32'h0);
    @(negedge clk);
    chk("wr_rspv", 32'(a.rsp_valid), 32'h2);
    @(negedge clk);
    a.req_valid = 2'b01; a.req_addr[28:0] = 29'h1C00; a.req_wren[3:0] = 4'hF; a.req_wdata[31:0] = 32'h1234;
    a.mmio_data_out = 32'h77;
    #1 chk("um_ready", 32'(a.req_ready), 32'h1);
    @(negedge clk);
    a.req_valid = 2'b00;
`ifdef MCPU_SOC_MMIO_ARB_DECERR_EN
    #1 chk("um_wren", 32'(a.mmio_wren), 32'h0);
`else
    #1 chk("um_wren", 32'(a.mmio_wren), 32'hF);
`endif
    chk("um_addr", 32'(a.mmio_addr), 32'h1C00);
    repeat (2) @(negedge clk);
    chk("um_rspv", 32'(a.rsp_valid), 32'h1);
`ifdef MCPU_SOC_MMIO_ARB_DECERR_EN
    chk("um_err", 32'(a.rsp_err), 32'h1);
    chk("um_data", a.rsp_data, 32'hDEADBEEF);
`else
    chk("um_err", 32'(a.rsp_err), 32'h0);
    chk("um_data", a.rsp_data, 32'h77);
`endif
    @(negedge clk);
    a.req_valid = 2'b01; a.req_addr[28:0] = 29'h800; a.req_wren[3:0] = 4'h0; a.mmio_data_out = 32'h99;
    #1 chk("ab_ready", 32'(a.req_ready), 32'h1);
    @(negedge clk);
    a.req_valid = 2'b00;
    @(negedge clk);
    chk("ab_addr_wait", 32'(a.mmio_addr), 32'h800);
    rst = 1'b1;
    #1 chk("ab_addr", 32'(a.mmio_addr), 32'h0);
    chk("ab_data", a.rsp_data, 32'h0);
    chk("ab_rspv", 32'(a.rsp_valid), 32'h0);
    @(negedge clk);
    chk("ab_rspv_late", 32'(a.rsp_valid), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    a.req_valid = 2'b11; a.req_addr[28:0] = 29'h10; a.req_addr[57:29] = 29'h20;
    #1 chk("ab_next", 32'(a.req_ready), 32'h1);
    @(negedge clk);
    a.req_valid = 2'b00;
    repeat (4) @(negedge clk);
    b.req_addr = {29'h20, 29'h10};
    b.req_valid = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      eg = (k % 2 == 1) ? 2'b10 : 2'b01;
      ea = (k % 2 == 1) ? 32'h21 : 32'h11;
      chk("ct_ready", 32'(b.req_ready), 32'(eg));
      @(negedge clk);
      repeat (2) @(negedge clk);
      chk("ct_mid", 32'(b.rsp_valid), 32'h0);
      repeat (2) @(negedge clk);
      chk("ct_rspv", 32'(b.rsp_valid), 32'(eg));
      chk("ct_data", b.rsp_data, ea);
      @(negedge clk);
    end
    b.req_valid = 2'b00;
    c.req_addr = {29'h30, 29'h20, 29'h10};
    c.req_valid = 3'b010;
    #1 chk("p3_first", 32'(c.req_ready), 32'h2);
    @(negedge clk);
    c.req_valid = 3'b000;
    repeat (3) @(negedge clk);
    c.req_valid = 3'b111;
    #1 chk("p3_g0", 32'(c.req_ready), 32'h4);
    repeat (3) @(negedge clk);
    chk("p3_g0_data", c.rsp_data, 32'h31);
    @(negedge clk);
    chk("p3_g1", 32'(c.req_ready), 32'h1);
    repeat (4) @(negedge clk);
    chk("p3_g2", 32'(c.req_ready), 32'h2);
    c.req_valid = 3'b000;
    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
